// File: rtl/dgldpc_shuffled_vnu.sv
// Shuffled-schedule DGLDPC variable-node update: a-posteriori total plus four extrinsic messages, 1/cycle, no backpressure.
// Latency 1 cycle, or 2 when DGLDPC_VNU_INREG_EN adds a reset-to-zero input register stage.
module dgldpc_shuffled_vnu (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      i_LOVNU,
  input  logic [0:3][5:0] i_data,
  output logic [0:4][8:0] o_data
);

  logic [7:0]      llr;
  logic [0:3][5:0] msg;

`ifdef DGLDPC_VNU_INREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      llr <= '0;
      msg <= '0;
    end else begin
      llr <= i_LOVNU;
      msg <= i_data;
    end
  end
`else
  assign llr = i_LOVNU;
  assign msg = i_data;
`endif

  logic signed [9:0] llr_ext;
  logic signed [9:0] msg_ext [4];
  logic signed [9:0] total;
  logic signed [9:0] extr    [4];

  // Worst-case magnitudes fit in 9 bits, so the 10-bit sums never wrap.
  always_comb begin
    llr_ext = {{2{llr[7]}}, llr};
    total   = llr_ext;
    for (int k = 0; k < 4; k++) begin
      msg_ext[k] = {{4{msg[k][5]}}, msg[k]};
      total      = total + msg_ext[k];
    end
    for (int k = 0; k < 4; k++) begin
      extr[k] = total - msg_ext[k];
    end
  end

  // Bit 9 only carries redundant sign information once the range is bounded.
  logic unused_msbs;
  assign unused_msbs = ^{total[9], extr[0][9], extr[1][9], extr[2][9], extr[3][9]};

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        o_data[k] <= extr[k][8:0];
      end
      o_data[4] <= total[8:0];
    end
  end

endmodule

// File: tb/tb_dgldpc_shuffled_vnu.sv
// Self-checking bench for dgldpc_shuffled_vnu: directed vectors, static hold, reset cases and random stream.
// Expected outputs are queued at drive time and popped once the configured latency has elapsed.
module tb_dgldpc_shuffled_vnu;

`ifdef DGLDPC_VNU_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk;
  logic            rst;
  logic [7:0]      i_LOVNU;
  logic [0:3][5:0] i_data;
  logic [0:4][8:0] o_data;

  int checks   = 0;
  int failures = 0;

  logic [0:4][8:0] sb_q  [$];
  string           tag_q [$];

  dgldpc_shuffled_vnu dut (
    .clk     (clk),
    .rst     (rst),
    .i_LOVNU (i_LOVNU),
    .i_data  (i_data),
    .o_data  (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:4][8:0] model(input logic [7:0] l, input logic [0:3][5:0] d);
    logic [0:4][8:0] r;
    int t;
    int e;
    t = int'($signed(l));
    for (int k = 0; k < 4; k++) t = t + int'($signed(d[k]));
    r[4] = t[8:0];
    for (int k = 0; k < 4; k++) begin
      e = t - int'($signed(d[k]));
      r[k] = e[8:0];
    end
    return r;
  endfunction

  // Drive one input set at the negedge, queue its expected result, then check at the next negedge.
  task automatic step(input logic r, input logic [7:0] l, input logic [0:3][5:0] d,
                      input logic [0:4][8:0] exp_v, input string tag);
    logic [0:4][8:0] exp_o;
    string           t_o;
    rst     = r;
    i_LOVNU = l;
    i_data  = d;
    if (r) begin
      for (int i = 0; i < sb_q.size(); i++) sb_q[i] = '0;
    end
    sb_q.push_back(r ? 45'd0 : exp_v);
    tag_q.push_back(r ? "reset" : tag);
    @(negedge clk);
    if (sb_q.size() == LAT) begin
      exp_o = sb_q.pop_front();
      t_o   = tag_q.pop_front();
      checks++;
      assert (o_data === exp_o) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t_o, o_data, exp_o);
      end
    end
  endtask

  task automatic step_m(input logic r, input logic [7:0] l, input logic [0:3][5:0] d, input string tag);
    step(r, l, d, model(l, d), tag);
  endtask

  initial begin
    logic [7:0]      l;
    logic [0:3][5:0] d;
    int              rst_at;

    rst     = 1'b1;
    i_LOVNU = '0;
    i_data  = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 24'h0, 45'd0, "reset");

    step(1'b0, 8'h00, 24'h0, 45'd0, "all_zero");
    step(1'b0, 8'h05, {6'd1, 6'd2, 6'd3, 6'd4},
         {9'd14, 9'd13, 9'd12, 9'd11, 9'd15}, "small_pos");
    step(1'b0, 8'h80, {4{6'h20}},
         {9'h120, 9'h120, 9'h120, 9'h120, 9'h100}, "most_neg");
    step(1'b0, 8'h7F, {4{6'h1F}},
         {9'h0DC, 9'h0DC, 9'h0DC, 9'h0DC, 9'h0FB}, "most_pos");
    step(1'b0, 8'hF6, {6'h3F, 6'd5, 6'h30, 6'd0},
         {9'h1EB, 9'h1E5, 9'h1FA, 9'h1EA, 9'h1EA}, "mixed_sign");

    for (int i = 0; i < 3; i++)
      step(1'b0, 8'hF6, {6'h3F, 6'd5, 6'h30, 6'd0},
           {9'h1EB, 9'h1E5, 9'h1FA, 9'h1EA, 9'h1EA}, "static_hold");

    // Reset with live non-zero inputs on the same edge, then recovery.
    step(1'b1, 8'h7F, {4{6'h1F}}, 45'd0, "reset");
    step(1'b0, 8'h05, {6'd1, 6'd2, 6'd3, 6'd4},
         {9'd14, 9'd13, 9'd12, 9'd11, 9'd15}, "post_reset");

    rst_at = 60;
    for (int i = 0; i < 150; i++) begin
      l = 8'($urandom);
      d = 24'($urandom);
      if (i == rst_at || i == rst_at + 1) step(1'b1, l, d, 45'd0, "reset");
      else step_m(1'b0, l, d, "random");
    end

    for (int i = 0; i < LAT; i++) step(1'b0, 8'h00, 24'h0, 45'd0, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
